// File: rtl/grn_pkg.sv
// Shared GRN definitions: line width, write-buffer depth and the write-buffer
// producer FSM state type.
package grn_pkg;

  localparam int GRN_WRBUF_DEPTH = 16;
  localparam int GRN_LINE_W      = 512;

  typedef logic [GRN_LINE_W-1:0] t_grn_line;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_ACK  = 1'b1
  } t_grn_wrbuf_state;

endpackage

// File: rtl/grn_wrbuf_fifo.sv
// Register-array FIFO behind the GRN write buffer: fall-through head,
// occupancy counter and full/almost-full flags.
module grn_wrbuf_fifo
  import grn_pkg::*;
#(
  parameter int DEPTH     = GRN_WRBUF_DEPTH,
  parameter int DATA_W    = GRN_LINE_W,
  parameter int AFULL_LVL = DEPTH - 4,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_afull,
  output logic [PTR_W:0]    o_count
);

  localparam logic [PTR_W:0] L_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] L_AFULL = (PTR_W+1)'(AFULL_LVL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push = i_push && (r_count != L_FULL);
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Simultaneous push and pop moves both pointers and leaves occupancy alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rdPtr] : '0;
  assign o_full  = (r_count == L_FULL);
  assign o_afull = (r_count >= L_AFULL);
  assign o_count = r_count;

endmodule

// File: rtl/grn_write_buffer.sv
// Decoupling buffer between the GRN engine and the CCI-P write requestor.
// Optional statistics ports are enabled with `define GRN_WRBUF_STATS_EN.
module grn_write_buffer
  import grn_pkg::*;
#(
  parameter int DEPTH     = GRN_WRBUF_DEPTH,
  parameter int DATA_W    = GRN_LINE_W,
  parameter int AFULL_LVL = DEPTH - 4,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_write,
  input  logic [DATA_W-1:0] i_transient_in,
  output logic              o_ack_write,
  input  logic              i_finish_in,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_rd_ready,
  output logic              o_finish_out,
  output logic              o_wr_afull,
  output logic [31:0]       o_lines_in,
  output logic [31:0]       o_lines_out
`ifdef GRN_WRBUF_STATS_EN
  ,
  output logic [31:0]       o_stall_full_cycles,
  output logic [PTR_W:0]    o_max_occupancy
`endif
);

  t_grn_wrbuf_state r_state;
  t_grn_wrbuf_state w_nextState;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic [PTR_W:0]   w_count;
  logic             r_finLatch;
  logic             r_finishOut;
  logic [31:0]      r_linesIn;
  logic [31:0]      r_linesOut;

  grn_wrbuf_fifo #(
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .AFULL_LVL(AFULL_LVL)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_push (w_push),
    .i_data (i_transient_in),
    .i_pop  (w_pop),
    .o_valid(o_rd_valid),
    .o_data (o_rd_data),
    .o_full (w_full),
    .o_afull(o_wr_afull),
    .o_count(w_count)
  );

  assign w_pop = o_rd_valid && i_rd_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= WB_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // ACK is a dead cycle so the engine's late-dropping request is not recaptured.
  always_comb begin
    w_nextState = r_state;
    w_push      = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (i_req_write && !w_full) begin
          w_push      = 1'b1;
          w_nextState = WB_ACK;
        end
      end
      WB_ACK:  w_nextState = WB_IDLE;
      default: w_nextState = WB_IDLE;
    endcase
  end

  assign o_ack_write = (r_state == WB_ACK);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_finLatch  <= 1'b0;
      r_finishOut <= 1'b0;
      r_linesIn   <= '0;
      r_linesOut  <= '0;
    end else begin
      if (i_finish_in) begin
        r_finLatch <= 1'b1;
      end
      r_finishOut <= r_finLatch && (w_count == '0) && (r_state == WB_IDLE) && !i_req_write;
      if (w_push) begin
        r_linesIn <= r_linesIn + 32'd1;
      end
      if (w_pop) begin
        r_linesOut <= r_linesOut + 32'd1;
      end
    end
  end

  assign o_finish_out = r_finishOut;
  assign o_lines_in   = r_linesIn;
  assign o_lines_out  = r_linesOut;

`ifdef GRN_WRBUF_STATS_EN
  logic [31:0]    r_stallCycles;
  logic [PTR_W:0] r_maxOcc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stallCycles <= '0;
      r_maxOcc      <= '0;
    end else begin
      if ((r_state == WB_IDLE) && i_req_write && w_full) begin
        r_stallCycles <= r_stallCycles + 32'd1;
      end
      if (w_count > r_maxOcc) begin
        r_maxOcc <= w_count;
      end
    end
  end

  assign o_stall_full_cycles = r_stallCycles;
  assign o_max_occupancy     = r_maxOcc;
`endif

endmodule

// File: doc/grn_write_buffer.md
Name: grn_write_buffer

Overview:
- Decoupling buffer between the GRN engine (producer of 512-bit transient state lines) and the GRN requestor (issuer of CCI-P writes).
- Accepts lines over the engine's req_write/ack_write handshake and stores them in a FIFO.
- Presents lines to the requestor over valid/ready and holds back the engine's finish until every buffered line has been drained.

Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 4.
- DATA_W, 512: line width in bits; one CCI-P cache line.
- AFULL_LVL, DEPTH-4: occupancy at or above which wr_afull asserts.

Ports:
- clk  in  1  single clock for the whole block (CCI-P clock domain, pClkDiv2 at top level).
- rst_n  in  1  asynchronous, active-low reset.
- req_write  in  1  engine request; transient_in is valid while it is high.
- transient_in  in  DATA_W  line from the engine.
- ack_write  out  1  one-cycle pulse; the line has been captured.
- finish_in  in  1  engine done; level, sticky until reset.
- rd_valid  out  1  head line available to the requestor.
- rd_data  out  DATA_W  head line.
- rd_ready  in  1  requestor pops the head line when rd_valid is also high.
- finish_out  out  1  engine done and FIFO drained.
- wr_afull  out  1  occupancy is at or above AFULL_LVL.
- lines_in  out  32  count of lines accepted.
- lines_out  out  32  count of lines popped.

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0, pointers and occupancy are 0, the producer FSM is in IDLE, and the finish latch is cleared.
- Producer FSM, state IDLE:
  - req_write=1 and the FIFO is not full: write transient_in, assert ack_write for one cycle, go to ACK.
  - req_write=1 and the FIFO is full: stay in IDLE with no ack. The engine holds req_write and its data.
- Producer FSM, state ACK:
  - Unconditionally return to IDLE; no capture happens in this cycle.
  - This absorbs the engine's one-cycle lag in dropping req_write, so the same line is never captured twice.
  - Maximum acceptance rate is one line per 2 cycles.
- Consumer side:
  - rd_valid = (occupancy != 0), driven from registers.
  - rd_data is the head entry; it is stable while rd_valid=1 and rd_ready=0.
  - A pop occurs when rd_valid=1 and rd_ready=1; the head advances on the next edge.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- Push while full: impossible by construction.
- Pop while empty: ignored.
- Full is judged on the current occupancy, so a pop in the same cycle does not enable a push. This is conservative and costs no extra logic.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits, range 0..DEPTH.
- Read latency: a line written at edge N is visible on rd_valid/rd_data after edge N. This is fall-through from the registered array; no RAM read latency.
- finish handling:
  - finish_in sets a sticky latch.
  - finish_out = latch AND occupancy==0 AND FSM==IDLE AND req_write==0, registered, so it asserts one cycle after the condition.
  - finish_in arriving while lines are buffered leaves finish_out low until the last pop.
- lines_in and lines_out increment on push and pop respectively and wrap at 2^32.
- Invariant: lines_in - lines_out == occupancy, modulo 2^32.
- Reset mid-transfer: buffered lines are discarded and the counters clear. The engine must be reset at the same time; the requestor does this through top_grn_reset.

Optional Feature:
- Macro: GRN_WRBUF_STATS_EN.
- Defined:
  - Adds output stall_full_cycles [31:0]: counts cycles with req_write=1 in IDLE and the FIFO full.
  - Adds output max_occupancy [log2(DEPTH):0]: high-water mark.
  - Both reset to 0. The requestor may expose them through DSM.
- Undefined: neither the ports nor the logic exist; the rest of the behaviour is identical.

Decomposition:
- grn_pkg gains:
  - GRN_WRBUF_DEPTH
  - GRN_LINE_W = 512
  - typedef t_grn_line (logic [511:0])
  - typedef t_grn_wrbuf_state enum {WB_IDLE, WB_ACK}
- Sub-module grn_wrbuf_fifo: storage array, pointers, occupancy, full/empty/afull flags.
- grn_write_buffer holds the producer FSM, the finish latch, the counters and the stats.

Test Plan:
- Single line: req_write=1 with data 0xA5..A5 -> ack_write pulses exactly once; rd_valid=1 the next cycle with rd_data=0xA5..A5; lines_in=1. Pop -> lines_out=1, rd_valid=0.
- Fill with rd_ready=0, DEPTH=16: push 16 distinct lines -> 16 acks; the 17th request gets no ack while held for 10 cycles; wr_afull=1 from occupancy 12. One pop -> the 17th is acked in IDLE on the next possible cycle.
- Ordering plus concurrency: rd_ready=1 continuously while pushing 100 incrementing lines -> output sequence 0..99 in order; occupancy never exceeds 1; lines_in=lines_out=100.
- Finish gating: 5 lines buffered, finish_in=1, rd_ready=0 -> finish_out stays 0. Drain all 5 -> finish_out=1 one cycle after the last pop.
- Async reset mid-stream: drop rst_n with 7 lines buffered, between clock edges -> rd_valid, ack_write, finish_out and the counters go to 0 immediately; after release, a fresh push behaves as in the single-line scenario.
- With GRN_WRBUF_STATS_EN: the Fill scenario -> stall_full_cycles=10 and max_occupancy=16; without the macro, the bench compiles with the ports absent.
